// File: rtl/phase_fetch.sv
// Two-phase fetch unit: alternates fetch/execute each clock and latches
// the instruction byte from program memory on every fetch edge.
module phase_fetch #(
    parameter int INSTR_W = 4,
    parameter int OPER_W  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [INSTR_W+OPER_W-1:0] D,
    output logic                      phase,
    output logic [INSTR_W-1:0]        instruction,
    output logic [OPER_W-1:0]         operand
);

    localparam int W = INSTR_W + OPER_W;

    logic         phase_q;
    logic         phase_d;
    logic [W-1:0] fetch_q;
    logic [W-1:0] fetch_d;

    // Capture only on edges that close a fetch phase; hold during execute.
    always_comb begin
        phase_d = ~phase_q;
        fetch_d = fetch_q;
        if (phase_q) begin
            fetch_d = D;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q <= 1'b0;
            fetch_q <= '0;
        end else begin
            phase_q <= phase_d;
            fetch_q <= fetch_d;
        end
    end

    assign phase       = phase_q;
    assign instruction = fetch_q[W-1:OPER_W];
    assign operand     = fetch_q[OPER_W-1:0];

endmodule

// File: tb/tb_phase_fetch.sv
// Self-checking bench for phase_fetch against an edge-count reference
// model: phase = edges-since-release mod 2, loads on even edges.
module tb_phase_fetch;

    logic       clk;
    logic       reset;
    logic [7:0] D;
    logic       phase;
    logic [3:0] instruction;
    logic [3:0] operand;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int         n_m;
    logic [7:0] reg_m;

    phase_fetch #(.INSTR_W(4), .OPER_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .D           (D),
        .phase       (phase),
        .instruction (instruction),
        .operand     (operand)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Apply D, take one rising edge, advance the model, settle 1 unit.
    task automatic tick(input logic [7:0] d);
        D = d;
        @(posedge clk);
        if (reset) begin
            n_m++;
            if (n_m % 2 == 0) reg_m = d;
        end
        #1;
    endtask

    task automatic release_reset();
        reset = 1'b1;
        n_m   = 0;
        reg_m = 8'h00;
    endtask

    task automatic async_pulse();
        reset = 1'b0;
        n_m   = 0;
        reg_m = 8'h00;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 6; i++) begin
            tick((i % 2 == 0) ? 8'b0100_1001 : 8'($urandom));
            total++;
            if ({phase, instruction, operand} !== 9'h000) begin
                bad++;
                $display("FAIL reset_hold[%0d] got=%b/%b/%b want=0/0000/0000",
                         i, phase, instruction, operand);
            end
        end
        @(negedge clk);
        total++;
        if ({phase, instruction, operand} !== 9'h000) begin
            bad++;
            $display("FAIL reset_hold_neg got=%b/%b/%b want=0/0000/0000",
                     phase, instruction, operand);
        end
    endtask

    task automatic test_release_fetch();
        release_reset();
        tick(8'b0100_1001);
        total++;
        if ({phase, instruction, operand} !== {1'b1, 8'h00}) begin
            bad++;
            $display("FAIL edge1 got=%b/%b/%b want=1/0000/0000",
                     phase, instruction, operand);
        end
        tick(8'b0100_1001);
        total++;
        if ({phase, instruction, operand} !== {1'b0, 4'b0100, 4'b1001}) begin
            bad++;
            $display("FAIL edge2 got=%b/%b/%b want=0/0100/1001",
                     phase, instruction, operand);
        end
    endtask

    task automatic test_hold_execute();
        tick(8'hA5);
        total++;
        if ({phase, instruction, operand} !== {1'b1, 8'h49}) begin
            bad++;
            $display("FAIL edge3_hold got=%b/%b/%b want=1/0100/1001",
                     phase, instruction, operand);
        end
        tick(8'h3C);
        total++;
        if ({phase, instruction, operand} !== {1'b0, 8'h3C}) begin
            bad++;
            $display("FAIL edge4_load got=%b/%b/%b want=0/0011/1100",
                     phase, instruction, operand);
        end
    endtask

    task automatic test_async_reset();
        #2;
        async_pulse();
        total++;
        if ({phase, instruction, operand} !== 9'h000) begin
            bad++;
            $display("FAIL async_clear got=%b/%b/%b want=0/0000/0000",
                     phase, instruction, operand);
        end
        #1;
        release_reset();
        tick(8'b0100_1001);
        total++;
        if ({phase, instruction, operand} !== {1'b1, 8'h00}) begin
            bad++;
            $display("FAIL restart_edge1 got=%b/%b/%b want=1/0000/0000",
                     phase, instruction, operand);
        end
        tick(8'b0100_1001);
        total++;
        if ({phase, instruction, operand} !== {1'b0, 8'h49}) begin
            bad++;
            $display("FAIL restart_edge2 got=%b/%b/%b want=0/0100/1001",
                     phase, instruction, operand);
        end
    endtask

    task automatic test_boundaries();
        tick(8'h00);
        tick(8'hF0);
        total++;
        if ({phase, instruction, operand} !== {1'b0, 4'hF, 4'h0}) begin
            bad++;
            $display("FAIL field_F0 got=%b/%b/%b want=0/1111/0000",
                     phase, instruction, operand);
        end
        tick(8'hFF);
        tick(8'h0F);
        total++;
        if ({phase, instruction, operand} !== {1'b0, 4'h0, 4'hF}) begin
            bad++;
            $display("FAIL field_0F got=%b/%b/%b want=0/0000/1111",
                     phase, instruction, operand);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                async_pulse();
                total++;
                if ({phase, instruction, operand} !== 9'h000) begin
                    bad++;
                    $display("FAIL rand_async[%0d] got=%b/%b/%b want=0/0/0",
                             i, phase, instruction, operand);
                end
                #1;
                release_reset();
            end
            tick(8'($urandom));
            total++;
            if ({phase, instruction, operand} !== {1'(n_m % 2), reg_m}) begin
                bad++;
                $display("FAIL rand[%0d] got=%b/%h%h want=%b/%h",
                         i, phase, instruction, operand,
                         1'(n_m % 2), reg_m);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a;
        logic [7:0] b;
        a = 8'($urandom);
        b = ~a;
        if (n_m % 2 == 1) tick(8'h00);
        tick(8'h11);
        tick(a);
        total++;
        if ({instruction, operand} !== a) begin
            bad++;
            $display("FAIL b2b_a got=%h%h want=%h", instruction, operand, a);
        end
        tick(8'h22);
        tick(b);
        total++;
        if ({instruction, operand} !== b) begin
            bad++;
            $display("FAIL b2b_b got=%h%h want=%h", instruction, operand, b);
        end
    endtask

    initial begin
        reset = 1'b0;
        D     = 8'b0100_1001;
        n_m   = 0;
        reg_m = 8'h00;
        test_reset();
        test_release_fetch();
        test_hold_execute();
        test_async_reset();
        test_boundaries();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
